// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between the instruction-fetch and data requesters.
// Data normally wins; a contended fetch wins after MAX_STREAK back-to-back data grants.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we_re,
  input  logic [3:0]        d_mask,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we_re,
  output logic [3:0]        mem_mask,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned StreakW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
  localparam int unsigned CntW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_STREAK);
  localparam logic [CntW-1:0]    CntLast   = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {StIdle, StIfWait, StDWait} state_e;

  state_e              state_q, state_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_re_q, mem_we_re_d;
  logic [3:0]          mem_mask_q, mem_mask_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q, d_valid_d;
  logic                busy_q, busy_d;
  logic                timeout_err_q, timeout_err_d;

  logic                grant_if, grant_d;
  logic                timed_out;
  logic [DATA_W-1:0]   rdata_sel;

  assign timed_out = (TIMEOUT != 0) && (cnt_q == CntLast);
  assign rdata_sel = mem_valid ? mem_rdata : '0;

  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_re_d   = mem_we_re_q;
    mem_mask_d    = mem_mask_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    busy_d        = busy_q;
    if_valid_d    = 1'b0;
    d_valid_d     = 1'b0;
    timeout_err_d = 1'b0;
    grant_if      = 1'b0;
    grant_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // In a completion cycle the finishing requester still shows its old req, so no grant
        // is made; this also guarantees mem_req stays low for at least one cycle.
        if (!if_valid_q && !d_valid_q) begin
          grant_if = if_req && (!d_req || streak_q == StreakMax);
          grant_d  = d_req && !grant_if;
        end
        if (grant_if) begin
          state_d     = StIfWait;
          mem_we_re_d = 1'b0;
          mem_mask_d  = 4'hF;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          streak_d    = '0;
        end else if (grant_d) begin
          state_d     = StDWait;
          mem_we_re_d = d_we_re;
          mem_mask_d  = d_mask;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != StreakMax) begin
            streak_d = streak_q + 1'b1;
          end
        end
        if (grant_if || grant_d) begin
          mem_req_d = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
        end
      end
      StIfWait, StDWait: begin
        if (mem_valid || timed_out) begin
          state_d       = StIdle;
          mem_req_d     = 1'b0;
          busy_d        = 1'b0;
          cnt_d         = '0;
          timeout_err_d = !mem_valid;
          if (state_q == StIfWait) begin
            if_valid_d = 1'b1;
            if_rdata_d = rdata_sel;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = mem_we_re_q ? '0 : rdata_sel;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      streak_q      <= '0;
      cnt_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_we_re_q   <= 1'b0;
      mem_mask_q    <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      if_valid_q    <= 1'b0;
      d_valid_q     <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_re_q   <= mem_we_re_d;
      mem_mask_q    <= mem_mask_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      if_valid_q    <= if_valid_d;
      d_valid_q     <= d_valid_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign if_rdata    = if_rdata_q;
  assign if_valid    = if_valid_q;
  assign d_rdata     = d_rdata_q;
  assign d_valid     = d_valid_q;
  assign mem_req     = mem_req_q;
  assign mem_we_re   = mem_we_re_q;
  assign mem_mask    = mem_mask_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, corner sequences and a
// randomized run against a transaction-level model of grant order and responses.
module tb_mem_arbiter;

  localparam int unsigned MaxStreak = 4;
  localparam int unsigned Timeout   = 8;
  localparam int          NumVec    = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we_re, mem_valid;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_mask;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_valid, mem_req, mem_we_re, busy, timeout_err;
  logic [3:0]  mem_mask;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic [3:0]  e_mask;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_to;
  } vec_t;

  vec_t vecs [NumVec];

  mem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MAX_STREAK(MaxStreak),
    .TIMEOUT   (Timeout)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .d_req      (d_req),
    .d_we_re    (d_we_re),
    .d_mask     (d_mask),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_valid    (d_valid),
    .mem_req    (mem_req),
    .mem_we_re  (mem_we_re),
    .mem_mask   (mem_mask),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic outs_any();
    return |{if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we_re, mem_mask, mem_addr,
             mem_wdata, busy, timeout_err};
  endfunction

  task automatic quiet(input string name);
    step();
    check(name, 64'({mem_req, busy, if_valid, d_valid, timeout_err}), 64'(0));
  endtask

  // Inputs must already be driven with the DUT idle and no pulse out: the next edge grants.
  task automatic do_txn(input logic exp_d, input logic [31:0] e_addr, input logic [3:0] e_mask,
                        input logic e_we, input logic [31:0] e_wdata, input int lat,
                        input logic [31:0] rd, input logic [31:0] e_rdata, input logic e_to);
    int waits;
    step();
    check("grant_req_busy", 64'({mem_req, busy}), 64'(2'b11));
    check("grant_addr", 64'(mem_addr), 64'(e_addr));
    check("grant_mask_we", 64'({mem_mask, mem_we_re}), 64'({e_mask, e_we}));
    check("grant_wdata", 64'(mem_wdata), 64'(e_wdata));
    waits = (lat >= int'(Timeout)) ? int'(Timeout) - 1 : lat;
    for (int i = 0; i < waits; i++) begin
      step();
      check("wait_quiet", 64'({mem_req, busy, if_valid, d_valid, timeout_err}), 64'(5'b11000));
    end
    if (lat < int'(Timeout)) begin
      mem_rdata = rd;
      mem_valid = 1'b1;
    end
    step();
    mem_valid = 1'b0;
    check("resp_valid", 64'({if_valid, d_valid}), exp_d ? 64'(2'b01) : 64'(2'b10));
    check("resp_rdata", exp_d ? 64'(d_rdata) : 64'(if_rdata), 64'(e_rdata));
    check("resp_timeout", 64'(timeout_err), 64'(e_to));
    check("resp_idle", 64'({mem_req, busy}), 64'(0));
    check("resp_addr_held", 64'(mem_addr), 64'(e_addr));
  endtask

  // Both requesters held; from streak 0 the order repeats MAX_STREAK data grants then a fetch.
  task automatic contend(input int n);
    logic        exp_d;
    logic [31:0] rd;
    if_req  = 1'b1;
    if_addr = 32'h40;
    d_req   = 1'b1;
    d_we_re = 1'b0;
    d_mask  = 4'h9;
    d_addr  = 32'h80;
    d_wdata = 32'h5A5A;
    for (int i = 0; i < n; i++) begin
      exp_d = (i % int'(MaxStreak + 1)) != int'(MaxStreak);
      rd    = $urandom;
      do_txn(exp_d, exp_d ? 32'h80 : 32'h40, exp_d ? 4'h9 : 4'hF, 1'b0,
             exp_d ? 32'h5A5A : 32'h0, 1, rd, rd, 1'b0);
      quiet("contend_gap");
    end
  endtask

  initial begin
    vec_t        v;
    int unsigned streak_m;
    logic        if_pend, d_pend, fetch_win, to;
    int          lat;
    logic [31:0] rd;

    vecs[0] = '{1'b0, 1'b0, 4'h0, 32'h100, 32'h0, 2, 32'h00500093,
                4'hF, 1'b0, 32'h0, 32'h00500093, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 32'h2004, 32'hABCD, 1, 32'h12345678,
                4'h3, 1'b1, 32'hABCD, 32'h0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 4'hF, 32'h3000, 32'h55, 0, 32'hDEADBEEF,
                4'hF, 1'b0, 32'h55, 32'hDEADBEEF, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 4'h1, 32'h4000, 32'h0, 20, 32'h99999999,
                4'h1, 1'b0, 32'h0, 32'h0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 4'h0, 32'h104, 32'h0, 7, 32'hCAFEF00D,
                4'hF, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 4'h0, 32'h108, 32'h0, 8, 32'h13579BDF,
                4'hF, 1'b0, 32'h0, 32'h0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 4'hC, 32'h5000, 32'h11223344, 8, 32'h2468ACE0,
                4'hC, 1'b1, 32'h11223344, 32'h0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 4'h6, 32'hFFFFFFFC, 32'h0, 3, 32'h0BADF00D,
                4'h6, 1'b0, 32'h0, 32'h0BADF00D, 1'b0};

    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    d_req     = 1'b0;
    d_we_re   = 1'b0;
    d_mask    = '0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_valid = 1'b0;
    mem_rdata = '0;
    #12;
    check("reset_outputs", 64'(outs_any()), 64'(0));
    step();
    rst = 1'b0;
    check("reset_idle", 64'(outs_any()), 64'(0));

    // Directed single-requester transactions.
    for (int i = 0; i < NumVec; i++) begin
      v = vecs[i];
      if (v.is_d) begin
        d_req   = 1'b1;
        d_we_re = v.we;
        d_mask  = v.mask;
        d_addr  = v.addr;
        d_wdata = v.wdata;
        if_req  = 1'b0;
      end else begin
        if_req  = 1'b1;
        if_addr = v.addr;
        d_req   = 1'b0;
        d_we_re = 1'b1;
        d_mask  = 4'h5;
        d_wdata = 32'hFFFF_FFFF;
      end
      do_txn(v.is_d, v.addr, v.e_mask, v.e_we, v.e_wdata, v.lat, v.rdata, v.e_rdata, v.e_to);
      if_req    = 1'b0;
      d_req     = 1'b0;
      mem_valid = v.e_to;  // stray response after a timeout must be ignored
      mem_rdata = 32'h7777_7777;
      quiet("post_quiet");
      mem_valid = 1'b0;
      check("rdata_hold", v.is_d ? 64'(d_rdata) : 64'(if_rdata), 64'(v.e_rdata));
    end

    // Fetch response pulse with if_req still high: no grant that cycle, grant the next.
    if_req  = 1'b1;
    if_addr = 32'h200;
    d_req   = 1'b0;
    do_txn(1'b0, 32'h200, 4'hF, 1'b0, 32'h0, 1, 32'h13, 32'h13, 1'b0);
    step();
    check("mask_no_regrant", 64'({mem_req, if_valid}), 64'(0));
    step();
    check("mask_next_grant", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h200}));
    mem_rdata = 32'h14;
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    check("mask_resp", 64'({if_valid, if_rdata}), 64'({1'b1, 32'h14}));
    if_req = 1'b0;
    quiet("mask_quiet");

    // Contention, then leave streak at MAX and reset asynchronously mid D_WAIT.
    contend(13);
    step();
    check("pre_reset_grant", 64'({mem_req, mem_addr}), 64'({1'b1, 32'h80}));
    step();
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", 64'(outs_any()), 64'(0));
    @(posedge clk);
    #1;
    check("reset_held", 64'(outs_any()), 64'(0));
    rst = 1'b0;
    contend(5);
    if_req = 1'b0;
    d_req  = 1'b0;
    quiet("contend_end");

    // Randomized run against a transaction-level model.
    streak_m = 0;
    if_pend  = 1'b1;
    d_pend   = 1'($urandom_range(0, 1));
    if_addr  = $urandom;
    d_addr   = $urandom;
    d_wdata  = $urandom;
    d_mask   = 4'($urandom);
    d_we_re  = 1'($urandom);
    if_req   = if_pend;
    d_req    = d_pend;
    for (int it = 0; it < 60; it++) begin
      fetch_win = if_pend && (!d_pend || streak_m == MaxStreak);
      lat       = int'($urandom_range(0, 10));
      rd        = $urandom;
      to        = lat >= int'(Timeout);
      if (fetch_win) begin
        do_txn(1'b0, if_addr, 4'hF, 1'b0, 32'h0, lat, rd, to ? 32'h0 : rd, to);
      end else begin
        do_txn(1'b1, d_addr, d_mask, d_we_re, d_wdata, lat, rd,
               (to || d_we_re) ? 32'h0 : rd, to);
      end
      if (fetch_win) begin
        streak_m = 0;
      end else if (!if_pend) begin
        streak_m = 0;
      end else if (streak_m < MaxStreak) begin
        streak_m++;
      end
      // The winner retires and may issue a fresh request at once; the loser keeps waiting.
      if (fetch_win) begin
        if_pend = 1'($urandom_range(0, 1));
        if_addr = $urandom;
      end else begin
        d_pend  = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_mask  = 4'($urandom);
        d_we_re = 1'($urandom);
      end
      if (!if_pend && !d_pend) begin
        if_pend = 1'($urandom_range(0, 1));
        d_pend  = !if_pend || 1'($urandom_range(0, 1));
      end
      if_req    = if_pend;
      d_req     = d_pend;
      mem_valid = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      quiet("rand_gap");
      mem_valid = 1'b0;
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    quiet("rand_end");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-ported memory interface between the core's instruction-fetch requester and data-memory (load/store) requester. It arbitrates requests and latches the winner's address, mask and write data. It drives a request/valid handshake to memory and routes the response back to the winner as a one-cycle valid pulse. It sits between the core's fetch/mem_stage memory ports and the unified memory; it also includes fetch-starvation protection and a response timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
MAX_STREAK, 4, consecutive contended data grants after which a pending fetch wins
TIMEOUT, 255, wait cycles before abandoning a transaction; 0 disables

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
if_req  in  1  fetch request; held until if_valid
if_addr  in  ADDR_W  fetch address (pc)
if_rdata  out  DATA_W  fetched instruction
if_valid  out  1  fetch response pulse
d_req  in  1  data request; held until d_valid
d_we_re  in  1  1=store, 0=load
d_mask  in  4  byte enables
d_addr  in  ADDR_W  data address (ALU result)
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data
d_valid  out  1  data response pulse
mem_req  out  1  memory request
mem_we_re  out  1  1=write
mem_mask  out  4  byte enables to memory
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
mem_valid  in  1  memory response
busy  out  1  transaction in flight
timeout_err  out  1  one-cycle pulse when a transaction times out

Behaviour:
- Reset (async, any state): all outputs 0, state IDLE, streak=0, wait counter=0.
- States: IDLE, IF_WAIT, D_WAIT.
- IDLE arbitration, evaluated each cycle:
  - Grant goes to data if d_req is high, unless if_req is also high and streak==MAX_STREAK; in that case fetch wins.
  - A requester whose valid pulse is on its output this cycle is masked out of arbitration.
- On grant:
  - Latch addr/mask/wdata/we_re into the mem_* registers. Fetch uses mem_we_re=0, mem_mask=4'hF, mem_wdata=0.
  - Set mem_req=1 and busy=1 at the next edge, and go to IF_WAIT or D_WAIT.
  - Requester inputs are not sampled again until the transaction ends.
- Streak counter:
  - Increments (saturating at MAX_STREAK) on a data grant when if_req was also high.
  - Clears on any fetch grant, and on a data grant with if_req low.
- WAIT states:
  - mem_req and the mem_* fields stay stable; the wait counter increments each cycle.
  - On mem_valid=1: capture mem_rdata into if_rdata, or into d_rdata for loads (d_rdata=0 for stores). Pulse if_valid/d_valid for exactly one cycle at the next edge.
  - At that same edge: mem_req=0, busy=0, state to IDLE, counter cleared.
  - Minimum latency: grant edge, then mem_req, then the response pulse one cycle after mem_valid.
- Timeout (TIMEOUT>0):
  - If the counter reaches TIMEOUT with no mem_valid, perform the same completion with rdata=0 and timeout_err pulsed for one cycle.
  - A mem_valid arriving after a timeout, or any mem_valid in IDLE, is ignored.
- rdata outputs hold their last value between pulses.
- Back-to-back: at least one IDLE cycle between transactions. mem_req drops for at least one cycle.
- Reset asserted mid-transaction abandons it; no valid pulse is produced.

Test Plan:
- Fetch only: if_req=1, if_addr=0x100, mem_valid two cycles after mem_req with rdata=0x00500093 -> mem_addr=0x100, mem_mask=F, mem_we_re=0; if_rdata=0x00500093 with one-cycle if_valid; d_valid stays 0.
- Store only: d_req=1, d_we_re=1, d_addr=0x2004, d_mask=4'b0011, d_wdata=0xABCD -> mem_* match the inputs; d_valid pulses with d_rdata=0.
- Contention: both requests held continuously, MAX_STREAK=4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
- Timeout: TIMEOUT=8, d_req load, mem_valid never asserted -> after 8 wait cycles: d_valid and timeout_err pulse together, d_rdata=0, mem_req=0. A later stray mem_valid causes no pulse.
- Async reset mid-D_WAIT: all outputs go 0 immediately without a clock edge. After release, a fresh if_req is served normally and streak starts from 0.
- Simultaneous grant-masking: fetch response pulse coincides with if_req still high and d_req low -> no new fetch grant that cycle; the next fetch grant comes on the following cycle.
